// File: rtl/cache_mem_arbiter.sv
// Shares one single-ported RAM between icache (read-only) and dcache.
// Registered grant, dcache priority, bounded icache starvation, dlock keeps a two-word burst.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        dlock,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int unsigned SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              d_req;

  assign d_req = dREN | dWEN;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // RAM controls decode straight from the registered state, so an async reset
  // drops the enables immediately and abandons any partial transfer.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    scnt_d   = scnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Forced icache win is only evaluated here, so a locked burst is never split.
        if (iREN && (scnt_q == SCNT_MAX)) begin
          state_d = IGNT;
        end else if (d_req) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (ram_ready) begin
          iwait   = 1'b0;
          state_d = IDLE;
          scnt_d  = '0;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end

      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ram_ready) begin
          dwait   = 1'b0;
          state_d = dlock ? DGNT : IDLE;
          if (!iREN) begin
            scnt_d = '0;
          end else if (scnt_q != SCNT_MAX) begin
            scnt_d = scnt_q + 1'b1;
          end
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs driven 1ns after the rising edge,
// outputs sampled on the falling edge.
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic        dlock = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .dlock    (dlock),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    ramload = 32'h1234_5678;
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
    end
    checks++;
    if ({ramaddr, ramstore} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore});
    end
    checks++;
    if ({iload, dload} !== {32'h1234_5678, 32'h1234_5678}) begin
      errors++;
      $display("FAIL reset_load_pass: got %h want 1234567812345678", {iload, dload});
    end
    ram_ready = 1'b0;
    nRST = 1'b1;

    // Start a dcache write, then pull reset in the middle of the grant.
    next_cycle();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h200, 32'h55}) begin
      errors++;
      $display("FAIL reset_pre_dgnt: got %h want 1_00000200_00000055", {ramWEN, ramaddr, ramstore});
    end
    #2;
    nRST = 1'b0;
    ram_ready = 1'b1;
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_mid_access: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
    end
    checks++;
    if (ramaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_addr: got %h want 0", ramaddr);
    end
    dWEN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    next_cycle();
    @(negedge CLK);
    checks++;
    if (dut.scnt_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_scnt: got %0d want 0", dut.scnt_q);
    end
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== 34'h0) begin
      errors++;
      $display("FAIL reset_idle_after: got %h want 0", {ramREN, ramWEN, ramaddr});
    end
  endtask

  task automatic test_icache_read();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      errors++;
      $display("FAIL icache_decision_cycle: got %b want 00", {ramREN, ramWEN});
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      ram_ready = (c == 3);
      ramload   = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge CLK);
      checks++;
      if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
        errors++;
        $display("FAIL icache_grant c=%0d: got %h want 2_00000040", c, {ramREN, ramWEN, ramaddr});
      end
      checks++;
      if ({iwait, dwait} !== {(c != 3), 1'b1}) begin
        errors++;
        $display("FAIL icache_wait c=%0d: got %b want %b", c, {iwait, dwait}, {(c != 3), 1'b1});
      end
    end
    checks++;
    if (iload !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL icache_iload: got %h want deadbeef", iload);
    end
    next_cycle();
    iREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL icache_idle_after: got %h want 1", {ramREN, ramaddr, iwait});
    end
  endtask

  task automatic test_conflict();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80;
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h80, 2'b11}) begin
      errors++;
      $display("FAIL conflict_dgnt_first: got %h want dcache grant at 80", {ramREN, ramaddr, iwait, dwait});
    end
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramaddr, iwait, dwait} !== {32'h80, 2'b10}) begin
      errors++;
      $display("FAIL conflict_dcomplete: got %h want 80 with iwait=1 dwait=0", {ramaddr, iwait, dwait});
    end
    next_cycle();
    dREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL conflict_idle_gap: got %h want idle", {ramREN, ramaddr, iwait});
    end
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h44, 2'b01}) begin
      errors++;
      $display("FAIL conflict_ignt: got %h want icache grant at 44 completing", {ramREN, ramaddr, iwait, dwait});
    end
    next_cycle();
    iREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (dut.scnt_q !== 3'd0) begin
      errors++;
      $display("FAIL conflict_scnt_clear: got %0d want 0", dut.scnt_q);
    end
  endtask

  task automatic test_locked_burst();
    next_cycle();
    dWEN = 1'b1; dlock = 1'b1; daddr = 32'h100; dstore = 32'hA1;
    iREN = 1'b1; iaddr = 32'h48;
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore, iwait, dwait} !== {2'b10, 32'h100, 32'hA1, 2'b10}) begin
      errors++;
      $display("FAIL burst_word1: got %h want write 100/a1 dwait=0",
               {ramWEN, ramREN, ramaddr, ramstore, iwait, dwait});
    end
    next_cycle();
    daddr = 32'h104; dstore = 32'hA2; dlock = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore, iwait, dwait} !== {2'b10, 32'h104, 32'hA2, 2'b10}) begin
      errors++;
      $display("FAIL burst_word2: got %h want write 104/a2 dwait=0",
               {ramWEN, ramREN, ramaddr, ramstore, iwait, dwait});
    end
    next_cycle();
    dWEN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, ramaddr} !== 34'h0) begin
      errors++;
      $display("FAIL burst_idle_after: got %h want 0", {ramWEN, ramREN, ramaddr});
    end
    checks++;
    if (dut.scnt_q !== 3'd2) begin
      errors++;
      $display("FAIL burst_scnt: got %0d want 2", dut.scnt_q);
    end
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h48, 1'b0}) begin
      errors++;
      $display("FAIL burst_icache_after: got %h want icache 48 completing", {ramREN, ramaddr, iwait});
    end
    next_cycle();
    iREN = 1'b0; ram_ready = 1'b0;
  endtask

  task automatic test_starvation();
    string       pat = "IDIDIDIDIGIDIDI";
    logic [7:0]  g;
    logic [31:0] exp_addr;
    iaddr = 32'h4C; daddr = 32'h300;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next_cycle();
      iREN = (c <= 9);
      dREN = (c < 14);
      ram_ready = 1'b1;
      @(negedge CLK);
      g = pat[c];
      exp_addr = (g == "D") ? 32'h300 : (g == "G") ? 32'h4C : 32'h0;
      checks++;
      if ({ramREN, ramaddr, iwait, dwait} !== {(g != "I"), exp_addr, (g != "G"), (g != "D")}) begin
        errors++;
        $display("FAIL starve c=%0d: got ren=%b addr=%h iw=%b dw=%b want grant %s",
                 c, ramREN, ramaddr, iwait, dwait, string'(g));
      end
      if (c == 8) begin
        checks++;
        if (dut.scnt_q !== 3'd4) begin
          errors++;
          $display("FAIL starve_scnt_sat: got %0d want 4", dut.scnt_q);
        end
      end
      if (c == 10) begin
        checks++;
        if (dut.scnt_q !== 3'd0) begin
          errors++;
          $display("FAIL starve_scnt_clear: got %0d want 0", dut.scnt_q);
        end
      end
    end
    next_cycle();
    ram_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h50; dREN = 1'b1; daddr = 32'h500;
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h500, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_grant: got %h want dcache 500 waiting", {ramREN, ramaddr, dwait});
    end
    next_cycle();
    dREN = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, dwait} !== 2'b01) begin
      errors++;
      $display("FAIL withdraw_drop: got %b want 01", {ramREN, dwait});
    end
    next_cycle();
    dREN = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, dwait} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_idle: got %h want idle", {ramREN, ramaddr, dwait});
    end
    checks++;
    if (dut.scnt_q !== 3'd0) begin
      errors++;
      $display("FAIL withdraw_scnt: got %0d want 0", dut.scnt_q);
    end
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h500, 1'b0}) begin
      errors++;
      $display("FAIL withdraw_retry: got %h want dcache 500 completing", {ramREN, ramaddr, dwait});
    end
    next_cycle();
    dREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (dut.scnt_q !== 3'd1) begin
      errors++;
      $display("FAIL withdraw_scnt_inc: got %0d want 1", dut.scnt_q);
    end
    next_cycle();
    ram_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h50, 1'b0}) begin
      errors++;
      $display("FAIL withdraw_icache: got %h want icache 50 completing", {ramREN, ramaddr, iwait});
    end
    next_cycle();
    iREN = 1'b0; ram_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_conflict();
    test_locked_burst();
    test_starvation();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
